// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the parametrised FIFO buffer family.
//   DEF_DATA_W / DEF_DEPTH : default word width and entry count
//   addr_width(depth)      : bits needed to address 'depth' entries
//   cnt_width(depth)       : pointer/occupancy width, one wrap bit above the
//                            address so that 0..depth fits without ambiguity
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_DEPTH  = 8;

    // A depth of one would give a zero-width address, so clamp to one bit.
    function automatic int addr_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    function automatic int cnt_width(input int depth);
        return addr_width(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram_sp.sv
// ---------------------------------------------------------------------------
// fifo_ram_sp
// DEPTH x DATA_W register array with a synchronous write port and a
// registered, read-enabled output. The storage itself has no reset so it can
// map onto distributed RAM; only the output register is reset/cleared.
// Ports:
//   clk, rst       : clock and asynchronous active-high reset (output reg only)
//   clr            : synchronous clear of the output register
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr  : read request, data appears on rd_data after the edge
//   rd_data        : registered read data, holds when rd_en is low
// ---------------------------------------------------------------------------
module fifo_ram_sp
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          wr_en,
    input  logic [addr_width(DEPTH)-1:0]  wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          rd_en,
    input  logic [addr_width(DEPTH)-1:0]  rd_addr,
    output logic [DATA_W-1:0]             rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;

    // Storage array: plain synchronous write, no reset so contents survive
    // reset and the array stays RAM-inferable.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read samples mem before this edge's write lands, so a read and a
    // write to the same address in one cycle returns the old word.
    always_comb begin
        rd_data_d = rd_data_q;
        if (clr) begin
            rd_data_d = '0;
        end else if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    // Output register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_buffer_param.sv
// ---------------------------------------------------------------------------
// fifo_buffer_param
// Single-clock parametrised FIFO with occupancy count, programmable
// almost-full/almost-empty flags and sticky overflow/underflow errors.
// Ports:
//   Clk, Rst       : clock, asynchronous active-high reset
//   EN             : global enable, nothing changes (not even CLR) when low
//   CLR            : synchronous flush, wins over RD/WR
//   WR, dataIn     : write request and data
//   RD, dataOut    : read request and registered read data (1-cycle latency)
//   EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL : decodes of registered COUNT
//   COUNT          : occupancy 0..DEPTH
//   OVERFLOW, UNDERFLOW : sticky, cleared only by Rst or CLR
// ---------------------------------------------------------------------------
module fifo_buffer_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         EN,
    input  logic                         CLR,
    input  logic                         WR,
    input  logic                         RD,
    input  logic [DATA_W-1:0]            dataIn,
    output logic [DATA_W-1:0]            dataOut,
    output logic                         EMPTY,
    output logic                         FULL,
    output logic                         ALMOST_EMPTY,
    output logic                         ALMOST_FULL,
    output logic [cnt_width(DEPTH)-1:0]  COUNT,
    output logic                         OVERFLOW,
    output logic                         UNDERFLOW
);

    localparam int ADDR_W = addr_width(DEPTH);
    localparam int CNT_W  = cnt_width(DEPTH);

    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_LVL   = CNT_W'(AE_THRESH);
    localparam logic [CNT_W-1:0] PTR_STEP = CNT_W'(1);

    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             active;
    logic             flush;
    logic             wr_acc;
    logic             rd_acc;

    // Occupancy is the modulo difference of the wrap-bit pointers, so a full
    // FIFO (pointers equal in address, differing in wrap bit) reads as DEPTH.
    assign count        = wr_ptr_q - rd_ptr_q;
    assign COUNT        = count;
    assign EMPTY        = (count == '0);
    assign FULL         = (count == FULL_LVL);
    assign ALMOST_EMPTY = (count <= AE_LVL);
    assign ALMOST_FULL  = (count >= AF_LVL);
    assign OVERFLOW     = ovf_q;
    assign UNDERFLOW    = unf_q;

    // Accept decisions. A write into a full FIFO is still taken when a read
    // frees the head slot in the same cycle; a read of an empty FIFO is
    // never taken, even if a write arrives alongside it.
    always_comb begin
        active = EN & ~CLR;
        flush  = EN & CLR;
        wr_acc = active & WR & (~FULL | RD);
        rd_acc = active & RD & ~EMPTY;
    end

    // Next-state for pointers and sticky error flags. Flush zeroes
    // everything; otherwise each side advances independently and any
    // request that was refused latches its error flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_STEP;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_STEP;
            end
            if (active && WR && !wr_acc) begin
                ovf_d = 1'b1;
            end
            if (active && RD && !rd_acc) begin
                unf_d = 1'b1;
            end
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    fifo_ram_sp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (Clk),
        .rst     (Rst),
        .clr     (flush),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q[ADDR_W-1:0]),
        .wr_data (dataIn),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr_q[ADDR_W-1:0]),
        .rd_data (dataOut)
    );

endmodule

// File: tb/tb_fifo_buffer_param.sv
// ---------------------------------------------------------------------------
// tb_fifo_buffer_param
// Directed testbench for fifo_buffer_param at DATA_W=4, DEPTH=8,
// AF_THRESH=6, AE_THRESH=1, with hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_fifo_buffer_param;

    logic       Clk;
    logic       Rst;
    logic       EN;
    logic       CLR;
    logic       WR;
    logic       RD;
    logic [3:0] dataIn;
    logic [3:0] dataOut;
    logic       EMPTY;
    logic       FULL;
    logic       ALMOST_EMPTY;
    logic       ALMOST_FULL;
    logic [3:0] COUNT;
    logic       OVERFLOW;
    logic       UNDERFLOW;

    int vectorCount;
    int errorCount;

    fifo_buffer_param #(
        .DATA_W    (4),
        .DEPTH     (8),
        .AF_THRESH (6),
        .AE_THRESH (1)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .EN           (EN),
        .CLR          (CLR),
        .WR           (WR),
        .RD           (RD),
        .dataIn       (dataIn),
        .dataOut      (dataOut),
        .EMPTY        (EMPTY),
        .FULL         (FULL),
        .ALMOST_EMPTY (ALMOST_EMPTY),
        .ALMOST_FULL  (ALMOST_FULL),
        .COUNT        (COUNT),
        .OVERFLOW     (OVERFLOW),
        .UNDERFLOW    (UNDERFLOW)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Every comparison goes through here so the counters stay honest.
    task automatic checkOutput(input string tag, input logic [15:0] actual,
                               input logic [15:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)",
                     tag, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, then let the edge happen and settle 1 unit
    // past it so outputs are sampled away from the active edge.
    task automatic applyStimulus(input logic en, input logic clr,
                                 input logic wr, input logic rd,
                                 input logic [3:0] din);
        EN     = en;
        CLR    = clr;
        WR     = wr;
        RD     = rd;
        dataIn = din;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        vectorCount = 0;
        errorCount  = 0;
        Rst    = 1'b1;
        EN     = 1'b0;
        CLR    = 1'b0;
        WR     = 1'b0;
        RD     = 1'b0;
        dataIn = 4'h0;
        @(posedge Clk);
        @(posedge Clk);
        #1;

        // Reset values
        checkOutput("rst_count", 16'(COUNT), 16'd0);
        checkOutput("rst_empty", 16'(EMPTY), 16'd1);
        checkOutput("rst_full", 16'(FULL), 16'd0);
        checkOutput("rst_ae", 16'(ALMOST_EMPTY), 16'd1);
        checkOutput("rst_af", 16'(ALMOST_FULL), 16'd0);
        checkOutput("rst_dout", 16'(dataOut), 16'd0);
        checkOutput("rst_ovf", 16'(OVERFLOW), 16'd0);
        checkOutput("rst_unf", 16'(UNDERFLOW), 16'd0);
        Rst = 1'b0;

        // 1. Fill with 0..7
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'(i));
            checkOutput("fill_count", 16'(COUNT), 16'(i + 1));
            checkOutput("fill_ae", 16'(ALMOST_EMPTY), 16'((i + 1) <= 1));
            checkOutput("fill_af", 16'(ALMOST_FULL), 16'((i + 1) >= 6));
            checkOutput("fill_full", 16'(FULL), 16'(i == 7));
            checkOutput("fill_ovf", 16'(OVERFLOW), 16'd0);
        end

        // 2. Overflow, then drain in order
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'hF);
        checkOutput("ovf_flag", 16'(OVERFLOW), 16'd1);
        checkOutput("ovf_count", 16'(COUNT), 16'd8);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
            checkOutput("drain_dout", 16'(dataOut), 16'(i));
            checkOutput("drain_count", 16'(COUNT), 16'(7 - i));
        end
        checkOutput("drain_empty", 16'(EMPTY), 16'd1);

        // 3. Underflow; RD+WR on empty takes only the write
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
        checkOutput("unf_flag", 16'(UNDERFLOW), 16'd1);
        checkOutput("unf_dout", 16'(dataOut), 16'h7);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'hA);
        checkOutput("erw_count", 16'(COUNT), 16'd1);
        checkOutput("erw_dout", 16'(dataOut), 16'h7);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
        checkOutput("erw_read", 16'(dataOut), 16'hA);
        checkOutput("erw_empty", 16'(EMPTY), 16'd1);

        // 4. COUNT=3 then 10 cycles of RD+WR; pointers wrap past 7
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'(i));
        end
        checkOutput("s4_count", 16'(COUNT), 16'd3);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'(i + 3));
            checkOutput("s4_dout", 16'(dataOut), 16'(i));
            checkOutput("s4_count", 16'(COUNT), 16'd3);
        end

        // 5. Fill to 8 (A,B,C,D,E,F,0,1), then RD+WR while full
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'(13 + i));
        end
        checkOutput("s5_full", 16'(FULL), 16'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'h9);
        checkOutput("s5_dout", 16'(dataOut), 16'hA);
        checkOutput("s5_count", 16'(COUNT), 16'd8);
        for (int i = 0; i < 8; i++) begin
            logic [3:0] expWord;
            expWord = (i == 7) ? 4'h9 : 4'(11 + i);
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
            checkOutput("s5_drain", 16'(dataOut), 16'(expWord));
        end
        checkOutput("s5_empty", 16'(EMPTY), 16'd1);

        // 6. COUNT=5 with sticky errors held; EN=0 must freeze everything
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'(i + 1));
        end
        checkOutput("s6_count", 16'(COUNT), 16'd5);
        checkOutput("s6_ovf", 16'(OVERFLOW), 16'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'h3);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h4);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'h5);
        checkOutput("en0_count", 16'(COUNT), 16'd5);
        checkOutput("en0_ovf", 16'(OVERFLOW), 16'd1);
        checkOutput("en0_unf", 16'(UNDERFLOW), 16'd1);
        checkOutput("en0_dout", 16'(dataOut), 16'h9);

        // Flush wins over simultaneous RD/WR
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'h6);
        checkOutput("clr_count", 16'(COUNT), 16'd0);
        checkOutput("clr_empty", 16'(EMPTY), 16'd1);
        checkOutput("clr_ovf", 16'(OVERFLOW), 16'd0);
        checkOutput("clr_unf", 16'(UNDERFLOW), 16'd0);
        checkOutput("clr_dout", 16'(dataOut), 16'd0);

        // Burst after flush, then asynchronous reset between edges
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'h3);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'h4);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'h5);
        checkOutput("burst_dout", 16'(dataOut), 16'h3);
        checkOutput("burst_count", 16'(COUNT), 16'd2);
        #2;
        Rst = 1'b1;
        #1;
        checkOutput("arst_count", 16'(COUNT), 16'd0);
        checkOutput("arst_empty", 16'(EMPTY), 16'd1);
        checkOutput("arst_dout", 16'(dataOut), 16'd0);
        #2;
        Rst = 1'b0;

        // Works normally after the async reset
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'hC);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
        checkOutput("post_dout", 16'(dataOut), 16'hC);
        checkOutput("post_count", 16'(COUNT), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, errorCount);
        $finish;
    end

endmodule
